// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared definitions for the arbitrating multiplexer.
// Channel IDs name the requesters wired to the shared memory/bus port.
package arb_mux_pkg;

    typedef enum logic [1:0] {
        CH_IFETCH = 2'd0,
        CH_DMEM   = 2'd1,
        CH_DEBUG  = 2'd2
    } chan_id_e;

endpackage

// File: rtl/arb_mux_if.sv
// arb_mux_if: per-channel request handshakes plus the single output handshake.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface arb_mux_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [CW-1:0]             out_chan;
    logic                      out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/arb_mux_rr_pick.sv
// rr_pick: combinational rotating priority picker.
// Rotates the request vector right by base so the preferred channel lands at
// bit 0, isolates the lowest set bit, then rotates the result back.
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] base,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_gnt;

    // Rotate, pick lowest set bit (x & -x), rotate back.
    always_comb begin
        rot     = N'({req, req} >> base);
        rot_gnt = rot & (~rot + N'(1));
        grant   = N'(({rot_gnt, rot_gnt} << base) >> N);
    end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel arbitrating mux with a one-beat registered output stage.
// Define ARB_MUX_RR_EN for round-robin arbitration; otherwise the lowest-index
// valid channel always wins and no rotating pointer is built.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input logic     clk,
    input logic     rst,
    arb_mux_if.slave bus
);

    localparam int CW = $clog2(CHANNELS);

    logic                load;
    logic                xfer;
    logic [CW-1:0]       base;
    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       grant_idx;
    logic [WIDTH-1:0]    sel_data;

    assign load = !bus.out_valid || bus.out_ready;

`ifdef ARB_MUX_RR_EN
    logic [CW-1:0] ptr;

    // Move the highest-priority slot to the channel after the one just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
        end
    end

    assign base = ptr;
`else
    assign base = '0;
`endif

    rr_pick #(
        .N  (CHANNELS),
        .CW (CW)
    ) u_pick (
        .req   (bus.in_valid),
        .base  (base),
        .grant (grant)
    );

    // Grant is a subset of in_valid, so any ready bit means a transfer.
    assign bus.in_ready = (load && !rst) ? grant : '0;
    assign xfer         = |bus.in_ready;

    // Encode the one-hot grant and select the winning payload.
    always_comb begin
        grant_idx = '0;
        sel_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_idx = CW'(i);
                sel_data  = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: refill on transfer, otherwise empty when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_chan  <= grant_idx;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
